// File: rtl/gate_bist_pkg.sv
// Shared definitions for the gate self-test engine: mode codes, FSM encoding,
// and a reference golden function usable from simulation code.
package gate_bist_pkg;

  localparam int unsigned MODE_W = 3;
  localparam int unsigned ST_W   = 2;
  localparam int unsigned MAX_N  = 8;

  localparam logic [MODE_W-1:0] MODE_AND  = 3'd0;
  localparam logic [MODE_W-1:0] MODE_OR   = 3'd1;
  localparam logic [MODE_W-1:0] MODE_XOR  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_NAND = 3'd3;
  localparam logic [MODE_W-1:0] MODE_NOR  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_XNOR = 3'd5;
  localparam logic [MODE_W-1:0] MODE_BUF  = 3'd6;
  localparam logic [MODE_W-1:0] MODE_NOT  = 3'd7;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

  // Expected gate output for the low n bits of vec under the given mode.
  function automatic logic golden(input logic [MODE_W-1:0] mode,
                                  input logic [MAX_N-1:0]  vec,
                                  input int unsigned       n);
    logic r_and;
    logic r_or;
    logic r_xor;
    logic y;
    r_and = 1'b1;
    r_or  = 1'b0;
    r_xor = 1'b0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        r_and = r_and & vec[i];
        r_or  = r_or  | vec[i];
        r_xor = r_xor ^ vec[i];
      end
    end
    case (mode)
      MODE_AND:  y = r_and;
      MODE_OR:   y = r_or;
      MODE_XOR:  y = r_xor;
      MODE_NAND: y = ~r_and;
      MODE_NOR:  y = ~r_or;
      MODE_XNOR: y = ~r_xor;
      MODE_BUF:  y = vec[0];
      default:   y = ~vec[0];
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_bist_golden.sv
// Combinational golden model: N-bit reduction of the delayed vector per mode.
module gate_bist_golden
  import gate_bist_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [MODE_W-1:0] mode,
  input  logic [N-1:0]      vec,
  output logic              y_c
);

  // Select the reduction matching the latched gate function.
  always_comb begin
    y_c = 1'b0;
    case (mode)
      MODE_AND:  y_c = &vec;
      MODE_OR:   y_c = |vec;
      MODE_XOR:  y_c = ^vec;
      MODE_NAND: y_c = ~(&vec);
      MODE_NOR:  y_c = ~(|vec);
      MODE_XNOR: y_c = ~(^vec);
      MODE_BUF:  y_c = vec[0];
      MODE_NOT:  y_c = ~vec[0];
      default:   y_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_bist.sv
// Exhaustive-sweep self-test engine for an N-input gate with LAT-cycle response.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int unsigned N   = 2,
  parameter int unsigned LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MODE_W-1:0] mode,
  output logic [N-1:0]      pattern,
  input  logic              dut_y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N:0]        err_count,
  output logic [N-1:0]      first_fail,
  output logic              fail_valid
);

  localparam int unsigned CW   = N + 1;
  localparam int unsigned SW   = N + 1;
  localparam int unsigned DL   = (LAT == 0) ? 1 : LAT;
  localparam logic [N-1:0] LAST = {N{1'b1}};

  logic [ST_W-1:0]   state_q;
  logic [ST_W-1:0]   state_d;
  logic [MODE_W-1:0] mode_q;
  logic              iss_v_q;
  logic [SW-1:0]     dl_q [DL];
  logic [SW-1:0]     slot_c;
  logic              slot_v_c;
  logic [N-1:0]      slot_p_c;
  logic              gold_c;
  logic              start_ok_c;
  logic              cmp_c;
  logic              mism_c;

  // Slot under compare: live issue for LAT=0, else the tail of the delay line.
  assign slot_c   = (LAT == 0) ? {iss_v_q, pattern} : dl_q[DL-1];
  assign slot_v_c = slot_c[N];
  assign slot_p_c = slot_c[N-1:0];

  gate_bist_golden #(.N(N)) u_golden (
    .mode (mode_q),
    .vec  (slot_p_c),
    .y_c  (gold_c)
  );

  assign mism_c = cmp_c && (dut_y != gold_c);
  assign pass   = done && (err_count == '0);

  // Next-state logic; compare of the all-ones vector ends the sweep.
  always_comb begin
    state_d    = state_q;
    start_ok_c = 1'b0;
    cmp_c      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_RUN;
          start_ok_c = 1'b1;
        end
      end
      ST_RUN: begin
        cmp_c = slot_v_c;
        if (slot_v_c && (slot_p_c == LAST)) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with registered busy/done status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == ST_RUN);
      done    <= (state_d == ST_DONE);
    end
  end

  // Response delay line carrying {valid, pattern} to line up with dut_y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DL); i++) begin
        dl_q[i] <= '0;
      end
    end else begin
      dl_q[0] <= {iss_v_q, pattern};
      for (int i = 1; i < int'(DL); i++) begin
        dl_q[i] <= dl_q[i-1];
      end
    end
  end

  // Pattern issue, mismatch counting and first-failure capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= '0;
      iss_v_q    <= 1'b0;
      pattern    <= '0;
      err_count  <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
    end else if (start_ok_c) begin
      mode_q     <= mode;
      iss_v_q    <= 1'b1;
      pattern    <= '0;
      err_count  <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
    end else if (state_q == ST_RUN) begin
      if (iss_v_q) begin
        if (pattern == LAST) begin
          iss_v_q <= 1'b0;
        end else begin
          pattern <= pattern + N'(1);
        end
      end
      if (mism_c) begin
        err_count <= err_count + CW'(1);
        if (!fail_valid) begin
          first_fail <= slot_p_c;
          fail_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/gate_bist.md
# gate_bist

Parametrised self-test engine for the primitive-gate library. It replaces hand-written per-gate stimulus benches with synthesizable hardware. The engine drives an exhaustive input sweep into an N-input gate under test and compares each response against a built-in golden model for a selected gate function. It reports the mismatch count and the first failing vector. It sits beside any gate (or registered gate pipeline) in the combinational-circuits collection and serves both simulation and on-board checking.

## Interface
Parameters:
- N, 2, gate input count (1..8)
- LAT, 0, DUT response latency in clk cycles (0..3)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin sweep; sampled only in IDLE or DONE
- mode  in  3  gate function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 BUF(bit0), 7 NOT(bit0)
- pattern  out  N  registered input vector to DUT
- dut_y  in  1  DUT output
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  done and err_count == 0
- err_count  out  N+1  mismatches this sweep (max 2^N, no saturation needed)
- first_fail  out  N  pattern of first mismatch
- fail_valid  out  1  first_fail holds valid data

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on start. Same edge: latch mode, pattern←0, err_count←0, fail_valid←0, first_fail←0.
- RUN: pattern increments by 1 each cycle up to 2^N−1, then holds. Issue stops after the all-ones vector.
- Each issued vector enters a LAT-deep delay line carrying {valid, pattern}. LAT=0 means no delay.
- Golden = f(latched mode, delayed pattern). AND/OR/XOR are reductions over all N bits. NAND/NOR/XNOR are their inversions.
- Each valid delayed slot is compared with dut_y on that edge. On mismatch: err_count+1. If fail_valid=0, also set first_fail←delayed pattern and fail_valid←1.
- RUN → DONE on the edge that performs the compare of pattern 2^N−1.
- DONE: outputs hold. start → RUN with the same initialisation as from IDLE.
- start during RUN is ignored. mode changes during RUN are ignored.
- Reset at any time: state IDLE, delay line cleared. All outputs 0: pattern, busy, done, pass, err_count, first_fail, fail_valid.

## Timing
- E0 = edge sampling start=1. After E0: busy=1, pattern=0.
- Pattern p is visible after E_p for p ≤ 2^N−1. After that, pattern holds 2^N−1 through drain and DONE.
- Pattern p is compared at E_{p+1+LAT}.
- done rises after E_{2^N+LAT}. Total: 2^N+LAT+1 edges from start sample to done.
- busy falls on the same edge done rises.
- pass is combinational from done and err_count. There is no extra cycle.
- With LAT=0, dut_y must settle combinationally from pattern within one cycle.

## Structure
- Package gate_bist_pkg holds:
  - mode code localparams (MODE_AND … MODE_NOT)
  - state encoding
  - function golden(mode, vec) for simulation reuse
- One sub-module: gate_bist_golden. It is a combinational N-bit reduction per mode, instantiated once on the delayed pattern.
- Delay line and FSM live in the top module.

## Test plan
- N=2, LAT=0, correct 2-input AND, mode=0 → patterns 0,1,2,3; done after 5 edges; err_count=0; pass=1; fail_valid=0.
- N=2, LAT=0, AND DUT stuck-at-0, mode=0 → err_count=1; first_fail=2'b11; fail_valid=1; pass=0.
- N=2, LAT=0, correct AND DUT, mode=2 (XOR) → mismatches at 01, 10, 11; err_count=3; first_fail=2'b01.
- N=2, LAT=2, AND DUT behind 2 register stages, mode=0 → done after 7 edges; pass=1.
- N=4, LAT=0, OR DUT stuck-at-1, mode=1 → err_count=1; first_fail=4'b0000; done after 17 edges.
- Reset asserted asynchronously mid-sweep at pattern=2 → all outputs 0 immediately. A restart then runs the full sweep with fresh counts. A start pulse during RUN has no effect.
